// File: rtl/line_fill_buffer_pkg.sv
// Shared cache definitions for the line fill buffer: line geometry and FSM encoding.
package line_fill_buffer_pkg;
    localparam int LINE_WORDS = 16;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        FILL = 2'b01,
        DONE = 2'b10
    } lfb_state_e;
endpackage

// File: rtl/line_fill_buffer_decoder.sv
// 4-to-16 write-enable decoder: one-hot word enable for the line storage.
module decoder_4_to_16
    import line_fill_buffer_pkg::*;
(
    input  logic [IDX_W-1:0]      idx,
    input  logic                  en,
    output logic [LINE_WORDS-1:0] onehot
);
    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end
endmodule

// File: rtl/line_fill_buffer.sv
// Critical-word-first line fill buffer: collects 16 refill words starting at a
// wrapping offset, forwards the first word early and holds the line until acked.
module line_fill_buffer
    import line_fill_buffer_pkg::*;
#(
    parameter int BUS_WIDTH  = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic [IDX_W-1:0]                START_WORD,
    input  logic [BUS_WIDTH-1:0]            DATA_IN,
    input  logic                            DATA_IN_VALID,
    output logic                            DATA_IN_READY,
    output logic [BUS_WIDTH-1:0]            CRITICAL_WORD,
    output logic                            CRITICAL_VALID,
    output logic [LINE_WORDS*BUS_WIDTH-1:0] LINE_OUT,
    output logic                            LINE_VALID,
    input  logic                            LINE_ACK,
    output logic                            BUSY
);
    lfb_state_e state_q, state_d;
    logic [IDX_W-1:0] base_q, cnt_q, wr_idx;
    logic [LINE_WORDS-1:0] wr_en;
    logic [LINE_WORDS-1:0][BUS_WIDTH-1:0] line_q;
    logic [BUS_WIDTH-1:0] crit_q;
    logic crit_vld_q;
    logic accept, first_acc, last_acc;

    assign accept    = DATA_IN_VALID && (state_q == FILL);
    assign first_acc = accept && (cnt_q == '0);
    assign last_acc  = accept && (cnt_q == IDX_W'(LINE_WORDS - 1));
    // 4-bit add wraps the write slot 15 -> 0 for free.
    assign wr_idx    = base_q + cnt_q;

    decoder_4_to_16 u_dec (
        .idx    (wr_idx),
        .en     (accept),
        .onehot (wr_en)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (START) state_d = FILL;
            FILL:    if (last_acc) state_d = DONE;
            DONE:    if (LINE_ACK) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            crit_q     <= '0;
            crit_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            crit_vld_q <= first_acc;
            if (state_q == IDLE && START) begin
                base_q <= START_WORD;
                cnt_q  <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + IDX_W'(1);
            end
            if (first_acc) crit_q <= DATA_IN;
        end
    end

    // Storage persists across fills; only the decoded slot of an accepted word changes.
    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_word
        always_ff @(posedge CLK) begin
            if (RST)           line_q[i] <= '0;
            else if (wr_en[i]) line_q[i] <= DATA_IN;
        end
    end

    assign DATA_IN_READY  = (state_q == FILL);
    assign LINE_VALID     = (state_q == DONE);
    assign BUSY           = (state_q != IDLE);
    assign CRITICAL_WORD  = crit_q;
    assign CRITICAL_VALID = crit_vld_q;
    assign LINE_OUT       = line_q;
endmodule

// File: tb/tb_line_fill_buffer.sv
// Scoreboarded random bench for line_fill_buffer against a word-array line model.
module tb_line_fill_buffer;
    localparam int BW = 32;
    localparam int LW = 16;
    localparam int LB = LW * BW;

    logic          CLK = 1'b0;
    logic          RST, START, DATA_IN_VALID, LINE_ACK;
    logic [3:0]    START_WORD;
    logic [BW-1:0] DATA_IN;
    logic          DATA_IN_READY, CRITICAL_VALID, LINE_VALID, BUSY;
    logic [BW-1:0] CRITICAL_WORD;
    logic [LB-1:0] LINE_OUT;

    line_fill_buffer #(.BUS_WIDTH(BW), .LINE_WORDS(LW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .START_WORD(START_WORD),
        .DATA_IN(DATA_IN), .DATA_IN_VALID(DATA_IN_VALID), .DATA_IN_READY(DATA_IN_READY),
        .CRITICAL_WORD(CRITICAL_WORD), .CRITICAL_VALID(CRITICAL_VALID),
        .LINE_OUT(LINE_OUT), .LINE_VALID(LINE_VALID), .LINE_ACK(LINE_ACK), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [BW-1:0] model [LW];
    logic [BW-1:0] w [LW];
    logic [BW-1:0] exp_crit_q [$];
    logic [LB-1:0] exp_line_q [$];

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LB-1:0] model_flat();
        logic [LB-1:0] f;
        for (int i = 0; i < LW; i++) f[i*BW +: BW] = model[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, DATA_IN_READY, 0);
        chk({tag, "_cvalid"}, CRITICAL_VALID, 0);
        chk({tag, "_lvalid"}, LINE_VALID, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_cword"}, CRITICAL_WORD, 0);
        chk({tag, "_line"}, LINE_OUT, 0);
    endtask

    // Issue a fill of n_words words from w[]; gap_mode 0=none, 1=alternate, 2=random.
    task automatic do_fill(input logic [3:0] base, input int gap_mode, input int n_words);
        int t0, gaps;
        START = 1'b1; START_WORD = base;
        tick();
        START = 1'b0;
        t0 = cyc; gaps = 0;
        chk("busy_in_fill", BUSY, 1);
        chk("ready_in_fill", DATA_IN_READY, 1);
        exp_crit_q.push_back(w[0]);
        if (n_words == LW) begin
            for (int k = 0; k < LW; k++) model[(int'(base) + k) % LW] = w[k];
            exp_line_q.push_back(model_flat());
        end
        for (int k = 0; k < n_words; k++) begin
            if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                DATA_IN_VALID = 1'b0; DATA_IN = $urandom;
                tick();
                gaps++;
                chk("lvalid_in_gap", LINE_VALID, 0);
            end
            DATA_IN_VALID = 1'b1; DATA_IN = w[k];
            tick();
            chk("crit_pulse_timing", CRITICAL_VALID, k == 0);
            chk("lvalid_timing", LINE_VALID, k == LW - 1);
        end
        DATA_IN_VALID = 1'b0;
        if (n_words == LW) chk("fill_latency", cyc - t0, LW + gaps);
    endtask

    // Hold DONE for `hold` cycles (optionally driving START/DATA_IN_VALID), then ack.
    task automatic do_ack(input int hold, input bit noise);
        for (int i = 0; i < hold; i++) begin
            START = noise; DATA_IN_VALID = noise; DATA_IN = $urandom;
            tick();
            chk("hold_ready", DATA_IN_READY, 0);
            chk("hold_lvalid", LINE_VALID, 1);
            chk("hold_line", LINE_OUT, model_flat());
        end
        START = noise; DATA_IN_VALID = noise; LINE_ACK = 1'b1;
        tick();
        START = 1'b0; DATA_IN_VALID = 1'b0; LINE_ACK = 1'b0;
        chk("ack_busy", BUSY, 0);
        chk("ack_lvalid", LINE_VALID, 0);
        chk("ack_ready", DATA_IN_READY, 0);
    endtask

    task automatic rand_words();
        for (int k = 0; k < LW; k++) w[k] = $urandom;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a critical word or a line.
    int acc_cnt = 0;
    int crit_pulses = 0;
    logic lv_prev = 1'b0;
    initial forever begin
        @(negedge CLK);
        if (RST) begin
            acc_cnt = 0; crit_pulses = 0; lv_prev = 1'b0;
        end else begin
            if (DATA_IN_VALID && DATA_IN_READY) acc_cnt++;
            if (CRITICAL_VALID) begin
                crit_pulses++;
                if (exp_crit_q.size() == 0) chk("crit_unexpected", 1, 0);
                else chk("crit_word", CRITICAL_WORD, exp_crit_q.pop_front());
            end
            if (LINE_VALID && !lv_prev) begin
                if (exp_line_q.size() == 0) chk("line_unexpected", 1, 0);
                else chk("line_out", LINE_OUT, exp_line_q.pop_front());
                chk("accept_count", acc_cnt, LW);
                chk("crit_pulse_count", crit_pulses, 1);
                acc_cnt = 0; crit_pulses = 0;
            end
            lv_prev = LINE_VALID;
        end
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; START = 1'b0; START_WORD = '0; DATA_IN = '0;
        DATA_IN_VALID = 1'b0; LINE_ACK = 1'b0;
        for (int i = 0; i < LW; i++) model[i] = '0;
        tick(); tick();
        chk_reset_state("reset");
        RST = 1'b0;
        tick();
        chk("idle_busy", BUSY, 0);

        // Aligned fill
        for (int k = 0; k < LW; k++) w[k] = 32'h100 + k;
        do_fill(4'd0, 0, LW);
        chk("aligned_w0", LINE_OUT[0 +: BW], 32'h100);
        chk("aligned_w15", LINE_OUT[15*BW +: BW], 32'h10F);
        chk("aligned_crit", CRITICAL_WORD, 32'h100);
        do_ack(2, 1'b0);

        // Wrapped fill
        for (int k = 0; k < LW; k++) w[k] = 32'hA0 + k;
        do_fill(4'd13, 0, LW);
        chk("wrap_w13", LINE_OUT[13*BW +: BW], 32'hA0);
        chk("wrap_w15", LINE_OUT[15*BW +: BW], 32'hA2);
        chk("wrap_w0", LINE_OUT[0 +: BW], 32'hA3);
        chk("wrap_w12", LINE_OUT[12*BW +: BW], 32'hAF);
        chk("wrap_crit", CRITICAL_WORD, 32'hA0);
        do_ack(1, 1'b0);

        // Idle noise: valid data and ack outside FILL/DONE must do nothing
        DATA_IN_VALID = 1'b1; LINE_ACK = 1'b1; DATA_IN = $urandom;
        tick(); tick();
        DATA_IN_VALID = 1'b0; LINE_ACK = 1'b0;
        chk("idle_noise_busy", BUSY, 0);
        chk("idle_noise_line", LINE_OUT, model_flat());

        // Stalled fill, valid toggling 1/0
        rand_words();
        do_fill(4'($urandom_range(0, 15)), 1, LW);
        do_ack(1, 1'b0);

        // Hold and ignore for 10 cycles
        rand_words();
        do_fill(4'd5, 0, LW);
        do_ack(10, 1'b1);

        // Reset mid-fill with competing inputs, then a clean fill
        rand_words();
        do_fill(4'd2, 0, 7);
        RST = 1'b1; START = 1'b1; DATA_IN_VALID = 1'b1; LINE_ACK = 1'b1;
        tick();
        RST = 1'b0; START = 1'b0; DATA_IN_VALID = 1'b0; LINE_ACK = 1'b0;
        for (int i = 0; i < LW; i++) model[i] = '0;
        chk_reset_state("midfill_reset");
        tick();
        chk("post_reset_idle", BUSY, 0);
        for (int k = 0; k < LW; k++) w[k] = 32'hB0 + k;
        do_fill(4'd4, 0, LW);
        chk("restart_w4", LINE_OUT[4*BW +: BW], 32'hB0);
        chk("restart_w3", LINE_OUT[3*BW +: BW], 32'hBF);
        do_ack(0, 1'b0);

        // Early restart with random stalls
        rand_words();
        w[0] = 32'hDEADBEEF;
        do_fill(4'd9, 2, LW);
        chk("early_crit_word", CRITICAL_WORD, 32'hDEADBEEF);
        chk("early_crit_low", CRITICAL_VALID, 0);
        do_ack(1, 1'b0);

        // Random fills
        for (int r = 0; r < 6; r++) begin
            rand_words();
            do_fill(4'($urandom_range(0, 15)), 2, LW);
            do_ack(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        tick(); tick();
        chk("crit_queue_drained", exp_crit_q.size(), 0);
        chk("line_queue_drained", exp_line_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
